hififo_tx_arbiter: RTL

- Sits downstream of the TPC/FPC request generators and upstream of the PCIe core's 64-bit AXI-stream TX port.
- Accepts burst-style request packets (66-bit words) from NREQ sources and arbitrates round-robin per packet.
- Buffers each granted burst in an internal FIFO, because sources stream without backpressure after the grant.
- Drains the FIFO to the TX port with tkeep and tlast.

---
 rtl/hififo_tx_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/hififo_tx_arbiter.sv
// Round-robin per-packet arbiter: NREQ burst sources -> 66-bit word FIFO -> 64-bit AXI-stream TX.
// Optional packet/stall counters are built when HIFIFO_TX_ARB_STATS_EN is defined.
module hififo_tx_arbiter #(
  parameter int NREQ      = 2,
  parameter int DEPTH     = 64,
  parameter int MAX_WORDS = 18
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [66*NREQ-1:0] req_data,
  output logic [63:0]        tx_tdata,
  output logic [7:0]         tx_tkeep,
  output logic               tx_tlast,
  output logic               tx_tvalid,
  input  logic               tx_tready,
  output logic               busy,
  output logic               proto_err
`ifdef HIFIFO_TX_ARB_STATS_EN
  ,
  output logic [31:0]        pkt_count,
  output logic [31:0]        stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   MAX_L      = (AW+1)'(MAX_WORDS);
  localparam logic [CW-1:0] MAX_M1     = CW'(MAX_WORDS - 1);
  localparam logic [IW:0]   NREQ_L     = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST_SRC   = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, CAPTURE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] rr_reg, rr_next;
  logic [IW-1:0] win_reg, win_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          proto_reg, proto_next;

  logic          wr_en;
  logic [65:0]   wr_word;
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   occ;
  logic [AW:0]   free_space;
  logic          fifo_empty;
  logic          pop;

  logic [63:0]   tx_data_reg;
  logic [7:0]    tx_keep_reg;
  logic          tx_last_reg;
  logic          tx_valid_reg;

  // Per-source word view of the flat request bus
  logic [65:0] req_word [NREQ];
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*66 +: 66];
    end
  endgenerate

  // Rotate the valid vector so that bit 0 is the rr pointer; the lowest set bit is the winner offset.
  logic [2*NREQ-1:0] valid_dup;
  logic [NREQ-1:0]   valid_rot;
  logic [IW-1:0]     off;
  logic [IW:0]       pick_sum;
  logic [IW-1:0]     pick;
  logic              any_valid;
  logic [IW-1:0]     win_inc;

  assign valid_dup = {req_valid, req_valid} >> rr_reg;
  assign valid_rot = valid_dup[NREQ-1:0];
  assign any_valid = |req_valid;

  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) off = IW'(k);
    end
  end

  assign pick_sum = {1'b0, rr_reg} + {1'b0, off};
  assign pick     = (pick_sum >= NREQ_L) ? IW'(pick_sum - NREQ_L) : pick_sum[IW-1:0];
  assign win_inc  = (win_reg == LAST_SRC) ? '0 : win_reg + 1'b1;

  // Pointers carry one extra bit so a plain subtraction gives occupancy across wrap-around.
  assign occ        = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign free_space = DEPTH_L - occ;
  assign pop        = !fifo_empty && (!tx_valid_reg || tx_tready);

  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    win_next   = win_reg;
    cnt_next   = cnt_reg;
    proto_next = proto_reg;
    wr_en      = 1'b0;
    wr_word    = req_word[win_reg];
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (any_valid && (free_space >= MAX_L)) begin
          win_next   = pick;
          state_next = GRANT;
        end
      end
      GRANT: begin
        req_ready[win_reg] = 1'b1;
        if (req_valid[win_reg]) begin
          wr_en      = 1'b1;
          cnt_next   = CW'(1);
          state_next = CAPTURE;
        end else begin
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        wr_en    = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (wr_word[64]) begin
          state_next = IDLE;
          rr_next    = win_inc;
        end else if (cnt_reg == MAX_M1) begin
          // Overrun: terminate the packet here so the TX side still sees a framed burst
          wr_word[64] = 1'b1;
          proto_next  = 1'b1;
          state_next  = IDLE;
          rr_next     = win_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      rr_reg    <= '0;
      win_reg   <= '0;
      cnt_reg   <= '0;
      proto_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      win_reg   <= win_next;
      cnt_reg   <= cnt_next;
      proto_reg <= proto_next;
    end
  end

  logic [65:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Output stage doubles as the registered RAM read; it only reloads when empty or consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_keep_reg  <= '0;
      tx_last_reg  <= 1'b0;
    end else if (pop) begin
      tx_valid_reg <= 1'b1;
      tx_data_reg  <= mem[rd_ptr_reg[AW-1:0]][63:0];
      tx_last_reg  <= mem[rd_ptr_reg[AW-1:0]][64];
      tx_keep_reg  <= (mem[rd_ptr_reg[AW-1:0]][64] && mem[rd_ptr_reg[AW-1:0]][65]) ? 8'h0F : 8'hFF;
    end else if (tx_valid_reg && tx_tready) begin
      tx_valid_reg <= 1'b0;
    end
  end

  assign tx_tdata  = tx_data_reg;
  assign tx_tkeep  = tx_keep_reg;
  assign tx_tlast  = tx_last_reg;
  assign tx_tvalid = tx_valid_reg;
  assign proto_err = proto_reg;
  assign busy      = (state_reg != IDLE) || (occ != '0) || tx_valid_reg;

`ifdef HIFIFO_TX_ARB_STATS_EN
  logic [31:0] pkt_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (tx_valid_reg && tx_tready && tx_last_reg) pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
      if (tx_valid_reg && !tx_tready)               stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign pkt_count   = pkt_cnt_reg;
  assign stall_count = stall_cnt_reg;
`endif

endmodule
